// File: rtl/mem_access_seq.sv
// Request sequencer for the byte-wide MAR/MDR memory: turns byte/word read/write
// requests into the one-cycle-per-step control sequence and drives the shared bus.
module mem_access_seq #(
  parameter int unsigned ADDR_W   = 16,
  parameter bit          SIGN_EXT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic [15:0]       bus_out,
  output logic              bus_drive,
  input  logic [15:0]       mem_data,
  output logic              mar_load,
  output logic              mdr_load_bus,
  output logic              mdr_load_low,
  output logic              mdr_load_high,
  output logic              ram_write
);

  typedef enum logic [3:0] {
    IDLE,
    MAR_LO,
    RD_LO,
    MAR_HI,
    RD_HI,
    CAP,
    MDR_LO,
    WR_LO,
    MDR_HI,
    WR_HI
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              lat_write;
  logic              lat_word;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;

  logic              accept;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] addr_hi;
  logic              rsp_nxt;
  logic              mar_nxt;
  logic              mdr_bus_nxt;
  logic              mdr_low_nxt;
  logic              mdr_high_nxt;
  logic              ram_write_nxt;
  logic              drive_nxt;
  logic [15:0]       bus_nxt;
  logic [7:0]        ext;

  assign accept  = (state == IDLE) && req_valid;
  assign addr_hi = lat_addr + ADDR_W'(1);
  assign ext     = {8{SIGN_EXT && mem_data[7]}};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = req_valid ? MAR_LO : IDLE;
      MAR_LO:  state_nxt = lat_write ? MDR_LO : RD_LO;
      RD_LO:   state_nxt = lat_word ? MAR_HI : CAP;
      MAR_HI:  state_nxt = lat_write ? MDR_HI : RD_HI;
      RD_HI:   state_nxt = CAP;
      CAP:     state_nxt = IDLE;
      MDR_LO:  state_nxt = WR_LO;
      WR_LO:   state_nxt = lat_word ? MAR_HI : IDLE;
      MDR_HI:  state_nxt = WR_HI;
      WR_HI:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they register together
  // with it; on acceptance the request fields are not yet latched, so the raw
  // request address feeds the first MAR load.
  always_comb begin
    base_addr     = accept ? req_addr : lat_addr;
    mar_nxt       = 1'b0;
    mdr_bus_nxt   = 1'b0;
    mdr_low_nxt   = 1'b0;
    mdr_high_nxt  = 1'b0;
    ram_write_nxt = 1'b0;
    drive_nxt     = 1'b0;
    bus_nxt       = '0;
    unique case (state_nxt)
      MAR_LO: begin
        bus_nxt   = 16'(base_addr);
        drive_nxt = 1'b1;
        mar_nxt   = 1'b1;
      end
      MAR_HI: begin
        bus_nxt   = 16'(addr_hi);
        drive_nxt = 1'b1;
        mar_nxt   = 1'b1;
      end
      RD_LO:  mdr_low_nxt = 1'b1;
      RD_HI:  mdr_high_nxt = 1'b1;
      MDR_LO: begin
        bus_nxt     = {8'h00, lat_wdata[7:0]};
        drive_nxt   = 1'b1;
        mdr_bus_nxt = 1'b1;
      end
      MDR_HI: begin
        bus_nxt     = {8'h00, lat_wdata[15:8]};
        drive_nxt   = 1'b1;
        mdr_bus_nxt = 1'b1;
      end
      WR_LO, WR_HI: ram_write_nxt = 1'b1;
      default: ;
    endcase
    rsp_nxt = (state != IDLE) && (state_nxt == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      bus_out       <= '0;
      bus_drive     <= 1'b0;
      mar_load      <= 1'b0;
      mdr_load_bus  <= 1'b0;
      mdr_load_low  <= 1'b0;
      mdr_load_high <= 1'b0;
      ram_write     <= 1'b0;
      lat_write     <= 1'b0;
      lat_word      <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
    end else begin
      state         <= state_nxt;
      req_ready     <= (state_nxt == IDLE);
      rsp_valid     <= rsp_nxt;
      bus_out       <= bus_nxt;
      bus_drive     <= drive_nxt;
      mar_load      <= mar_nxt;
      mdr_load_bus  <= mdr_bus_nxt;
      mdr_load_low  <= mdr_low_nxt;
      mdr_load_high <= mdr_high_nxt;
      ram_write     <= ram_write_nxt;
      if (accept) begin
        lat_write <= req_write;
        lat_word  <= req_word;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (state == CAP) begin
        rsp_rdata <= lat_word ? mem_data : {ext, mem_data[7:0]};
      end
    end
  end

endmodule
